// File: rtl/imem_dmem_arbiter.sv
// rtl/imem_dmem_arbiter.sv - single-port BRAM arbiter between instruction fetch and load/store
module imem_dmem_arbiter #(
    parameter int XLEN         = 32,
    parameter int MEM_AW       = 12,
    parameter int HART_W       = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    input  logic [XLEN-1:0]   if_req_pc,
    input  logic [HART_W-1:0] if_req_hart,
    output logic              if_req_ready,
    output logic              if_rsp_valid,
    output logic [XLEN-1:0]   if_rsp_inst,
    output logic [XLEN-1:0]   if_rsp_pc,
    output logic [HART_W-1:0] if_rsp_hart,
    input  logic              d_req_valid,
    input  logic              d_req_we,
    input  logic [3:0]        d_req_be,
    input  logic [XLEN-1:0]   d_req_addr,
    input  logic [XLEN-1:0]   d_req_wdata,
    input  logic [HART_W-1:0] d_req_hart,
    output logic              d_req_ready,
    output logic              d_rsp_valid,
    output logic [XLEN-1:0]   d_rsp_rdata,
    output logic [HART_W-1:0] d_rsp_hart,
    input  logic              flush_valid,
    input  logic [HART_W-1:0] flush_hart,
    output logic              bram_en,
    output logic [3:0]        bram_we,
    output logic [MEM_AW-1:0] bram_addr,
    output logic [XLEN-1:0]   bram_wdata,
    input  logic [XLEN-1:0]   bram_rdata
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    logic [SC_W-1:0]   starve_cnt;
    logic              if_force;
    logic              grant_if;
    logic              grant_d;

    // Pending register: describes the access whose read data arrives this cycle
    logic              p_valid;
    logic              p_src_if;
    logic [HART_W-1:0] p_hart;
    logic [XLEN-1:0]   p_pc;
    logic              p_store;
    logic              p_kill;

    // Last delivered response values, shown while the matching valid is low
    logic [XLEN-1:0]   if_inst_q;
    logic [XLEN-1:0]   if_pc_q;
    logic [HART_W-1:0] if_hart_q;
    logic [XLEN-1:0]   d_rdata_q;
    logic [HART_W-1:0] d_hart_q;

    logic              flush_now;
    logic              if_deliver;
    logic              d_deliver;

    // Word index only: byte offset and bits above the BRAM size are dropped (aliasing)
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{d_req_addr[XLEN-1:MEM_AW+2], d_req_addr[1:0]};

    assign if_force     = if_req_valid && (starve_cnt == SC_W'(STARVE_LIMIT));
    assign grant_if     = if_req_valid && (!d_req_valid || if_force);
    assign grant_d      = d_req_valid && !grant_if;
    assign if_req_ready = grant_if;
    assign d_req_ready  = grant_d;

    // BRAM port drive for the winning requester
    always_comb begin
        bram_en    = 1'b0;
        bram_we    = 4'b0000;
        bram_addr  = '0;
        bram_wdata = '0;
        if (grant_if) begin
            bram_en   = 1'b1;
            bram_addr = if_req_pc[MEM_AW+1:2];
        end else if (grant_d) begin
            bram_en   = 1'b1;
            bram_addr = d_req_addr[MEM_AW+1:2];
            if (d_req_we) begin
                bram_we    = d_req_be;
                bram_wdata = d_req_wdata;
            end
        end
    end

    // Count consecutive cycles a waiting fetch has been denied
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!if_req_valid || grant_if) begin
            starve_cnt <= '0;
        end else if (starve_cnt != SC_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + SC_W'(1);
        end
    end

    // Capture the granted request so its response lines up with the BRAM read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_valid  <= 1'b0;
            p_src_if <= 1'b0;
            p_hart   <= '0;
            p_pc     <= '0;
            p_store  <= 1'b0;
            p_kill   <= 1'b0;
        end else begin
            p_valid <= grant_if || grant_d;
            if (grant_if || grant_d) begin
                p_src_if <= grant_if;
                p_hart   <= grant_if ? if_req_hart : d_req_hart;
                p_pc     <= if_req_pc;
                p_store  <= grant_d && d_req_we;
                p_kill   <= grant_if && flush_valid && (flush_hart == if_req_hart);
            end
        end
    end

    // A redirect of the fetching hart during the response cycle also squashes the fetch
    assign flush_now  = flush_valid && (flush_hart == p_hart);
    assign if_deliver = p_valid && p_src_if && !p_kill && !flush_now;
    assign d_deliver  = p_valid && !p_src_if;

    // Remember delivered responses so outputs hold while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_inst_q <= '0;
            if_pc_q   <= '0;
            if_hart_q <= '0;
            d_rdata_q <= '0;
            d_hart_q  <= '0;
        end else begin
            if (if_deliver) begin
                if_inst_q <= bram_rdata;
                if_pc_q   <= p_pc;
                if_hart_q <= p_hart;
            end
            if (d_deliver) begin
                d_rdata_q <= p_store ? '0 : bram_rdata;
                d_hart_q  <= p_hart;
            end
        end
    end

    assign if_rsp_valid = if_deliver;
    assign if_rsp_inst  = if_deliver ? bram_rdata : if_inst_q;
    assign if_rsp_pc    = if_deliver ? p_pc : if_pc_q;
    assign if_rsp_hart  = if_deliver ? p_hart : if_hart_q;
    assign d_rsp_valid  = d_deliver;
    assign d_rsp_rdata  = d_deliver ? (p_store ? '0 : bram_rdata) : d_rdata_q;
    assign d_rsp_hart   = d_deliver ? p_hart : d_hart_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb/tb_imem_dmem_arbiter.sv - directed self-checking bench for imem_dmem_arbiter
module tb_imem_dmem_arbiter;

    localparam logic [31:0] M0   = 32'h0010_0013;
    localparam logic [31:0] M1   = 32'h0020_0093;
    localparam logic [31:0] M2   = 32'h0030_0113;
    localparam logic [31:0] M4   = 32'h1122_3344;
    localparam logic [31:0] M128 = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst;
    logic        if_req_valid;
    logic [31:0] if_req_pc;
    logic [0:0]  if_req_hart;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_inst;
    logic [31:0] if_rsp_pc;
    logic [0:0]  if_rsp_hart;
    logic        d_req_valid;
    logic        d_req_we;
    logic [3:0]  d_req_be;
    logic [31:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic [0:0]  d_req_hart;
    logic        d_req_ready;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_rdata;
    logic [0:0]  d_rsp_hart;
    logic        flush_valid;
    logic [0:0]  flush_hart;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [11:0] bram_addr;
    logic [31:0] bram_wdata;
    logic [31:0] bram_rdata;

    logic [31:0] mem [0:4095];

    int n_cmp;
    int n_bad;

    imem_dmem_arbiter #(
        .XLEN(32), .MEM_AW(12), .HART_W(1), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_pc(if_req_pc), .if_req_hart(if_req_hart),
        .if_req_ready(if_req_ready), .if_rsp_valid(if_rsp_valid), .if_rsp_inst(if_rsp_inst),
        .if_rsp_pc(if_rsp_pc), .if_rsp_hart(if_rsp_hart),
        .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_be(d_req_be),
        .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_hart(d_req_hart),
        .d_req_ready(d_req_ready), .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
        .d_rsp_hart(d_rsp_hart),
        .flush_valid(flush_valid), .flush_hart(flush_hart),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port BRAM with one-cycle read latency
    always @(posedge clk) begin
        if (bram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
            end
            bram_rdata <= mem[bram_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, then settle before checks
    task automatic cyc(input logic r,
                       input logic iv, input logic [31:0] pc, input logic ih,
                       input logic dv, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd, input logic dh,
                       input logic fv, input logic fh);
        @(negedge clk);
        rst          = r;
        if_req_valid = iv;
        if_req_pc    = pc;
        if_req_hart  = ih;
        d_req_valid  = dv;
        d_req_we     = we;
        d_req_be     = be;
        d_req_addr   = addr;
        d_req_wdata  = wd;
        d_req_hart   = dh;
        flush_valid  = fv;
        flush_hart   = fh;
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0);
    endtask

    initial begin
        logic prev_if;
        logic prev_d;
        logic exp_if;
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[0]   = M0;
        mem[1]   = M1;
        mem[2]   = M2;
        mem[4]   = M4;
        mem[128] = M128;
        bram_rdata = 32'h0;
        rst = 1'b1;
        if_req_valid = 0; if_req_pc = 0; if_req_hart = 0;
        d_req_valid = 0; d_req_we = 0; d_req_be = 0; d_req_addr = 0; d_req_wdata = 0; d_req_hart = 0;
        flush_valid = 0; flush_hart = 0;

        // Reset state
        cyc(1, 0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0);
        check_eq("rst_if_valid", 32'(if_rsp_valid), 32'd0);
        check_eq("rst_d_valid", 32'(d_rsp_valid), 32'd0);
        check_eq("rst_if_inst", if_rsp_inst, 32'h0);
        check_eq("rst_d_rdata", d_rsp_rdata, 32'h0);
        check_eq("rst_bram_en", 32'(bram_en), 32'd0);

        // Consecutive fetches
        cyc(0, 1, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0);
        check_eq("f0_if_ready", 32'(if_req_ready), 32'd1);
        check_eq("f0_d_ready", 32'(d_req_ready), 32'd0);
        check_eq("f0_bram_en", 32'(bram_en), 32'd1);
        check_eq("f0_bram_addr", 32'(bram_addr), 32'd0);
        check_eq("f0_rsp_valid", 32'(if_rsp_valid), 32'd0);
        cyc(0, 1, 32'h4, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0);
        check_eq("f1_rsp_valid", 32'(if_rsp_valid), 32'd1);
        check_eq("f1_rsp_pc", if_rsp_pc, 32'h0);
        check_eq("f1_rsp_inst", if_rsp_inst, M0);
        cyc(0, 1, 32'h8, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0);
        check_eq("f2_rsp_pc", if_rsp_pc, 32'h4);
        check_eq("f2_rsp_inst", if_rsp_inst, M1);
        idle();
        check_eq("f3_rsp_valid", 32'(if_rsp_valid), 32'd1);
        check_eq("f3_rsp_pc", if_rsp_pc, 32'h8);
        check_eq("f3_rsp_inst", if_rsp_inst, M2);
        check_eq("idle_if_ready", 32'(if_req_ready), 32'd0);
        check_eq("idle_d_ready", 32'(d_req_ready), 32'd0);
        idle();
        check_eq("hold_rsp_valid", 32'(if_rsp_valid), 32'd0);
        check_eq("hold_rsp_pc", if_rsp_pc, 32'h8);
        check_eq("hold_rsp_inst", if_rsp_inst, M2);

        // Contention: data wins four times, then the starved fetch is forced through
        prev_if = 0;
        prev_d  = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 32'h4, 0, 1, 0, 4'h0, 32'h8, 32'h0, 0, 0, 0);
            exp_if = ((i % 5) == 4);
            check_eq($sformatf("starve%0d_if_ready", i), 32'(if_req_ready), 32'(exp_if));
            check_eq($sformatf("starve%0d_d_ready", i), 32'(d_req_ready), 32'(!exp_if));
            check_eq($sformatf("starve%0d_if_rsp", i), 32'(if_rsp_valid), 32'(prev_if));
            check_eq($sformatf("starve%0d_d_rsp", i), 32'(d_rsp_valid), 32'(prev_d));
            if (prev_d) check_eq($sformatf("starve%0d_d_rdata", i), d_rsp_rdata, M2);
            if (prev_if) check_eq($sformatf("starve%0d_inst", i), if_rsp_inst, M1);
            prev_if = exp_if;
            prev_d  = !exp_if;
        end
        idle();
        check_eq("starve_tail_if_rsp", 32'(if_rsp_valid), 32'd1);
        check_eq("starve_tail_inst", if_rsp_inst, M1);

        // Partial store then load of the same word
        cyc(0, 0, 32'h0, 0, 1, 1, 4'b0011, 32'h10, 32'hAABB_CCDD, 0, 0, 0);
        check_eq("st_d_ready", 32'(d_req_ready), 32'd1);
        check_eq("st_bram_we", 32'(bram_we), 32'h3);
        check_eq("st_bram_addr", 32'(bram_addr), 32'd4);
        check_eq("st_bram_wdata", bram_wdata, 32'hAABB_CCDD);
        cyc(0, 0, 32'h0, 0, 1, 0, 4'h0, 32'h10, 32'h0, 0, 0, 0);
        check_eq("ld_bram_we", 32'(bram_we), 32'h0);
        check_eq("st_ack_valid", 32'(d_rsp_valid), 32'd1);
        check_eq("st_ack_rdata", d_rsp_rdata, 32'h0);
        idle();
        check_eq("ld_valid", 32'(d_rsp_valid), 32'd1);
        check_eq("ld_rdata", d_rsp_rdata, 32'h1122_CCDD);

        // Flush of the fetching hart in the response cycle
        cyc(0, 1, 32'h200, 1, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0);
        check_eq("fl1_if_ready", 32'(if_req_ready), 32'd1);
        cyc(0, 0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 1);
        check_eq("fl1_killed", 32'(if_rsp_valid), 32'd0);
        // Flush of the other hart leaves the fetch alone
        cyc(0, 1, 32'h200, 1, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0);
        cyc(0, 0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 0);
        check_eq("fl2_valid", 32'(if_rsp_valid), 32'd1);
        check_eq("fl2_pc", if_rsp_pc, 32'h200);
        check_eq("fl2_hart", 32'(if_rsp_hart), 32'd1);
        check_eq("fl2_inst", if_rsp_inst, M128);
        // Flush in the grant cycle
        cyc(0, 1, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 0);
        idle();
        check_eq("fl3_killed", 32'(if_rsp_valid), 32'd0);
        // Flush never touches data responses
        cyc(0, 0, 32'h0, 0, 1, 0, 4'h0, 32'h8, 32'h0, 1, 0, 0);
        cyc(0, 0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 1);
        check_eq("fl4_d_valid", 32'(d_rsp_valid), 32'd1);
        check_eq("fl4_d_hart", 32'(d_rsp_hart), 32'd1);
        check_eq("fl4_d_rdata", d_rsp_rdata, M2);

        // Reset while a fetch is pending
        cyc(0, 1, 32'h4, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0);
        cyc(1, 0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0);
        check_eq("rp_if_valid", 32'(if_rsp_valid), 32'd0);
        check_eq("rp_if_pc", if_rsp_pc, 32'h0);
        check_eq("rp_d_rdata", d_rsp_rdata, 32'h0);
        idle();
        check_eq("rp_after_valid", 32'(if_rsp_valid), 32'd0);

        // Reset clears a saturated starve counter; grant during reset is dropped
        for (int i = 0; i < 4; i++) cyc(0, 1, 32'h4, 0, 1, 0, 4'h0, 32'h8, 32'h0, 0, 0, 0);
        cyc(1, 1, 32'h4, 0, 1, 0, 4'h0, 32'h8, 32'h0, 0, 0, 0);
        check_eq("rs_d_valid", 32'(d_rsp_valid), 32'd0);
        cyc(0, 1, 32'h4, 0, 1, 0, 4'h0, 32'h8, 32'h0, 0, 0, 0);
        check_eq("rs_d_ready", 32'(d_req_ready), 32'd1);
        check_eq("rs_if_ready", 32'(if_req_ready), 32'd0);
        check_eq("rs_no_if_rsp", 32'(if_rsp_valid), 32'd0);
        check_eq("rs_no_d_rsp", 32'(d_rsp_valid), 32'd0);
        cyc(0, 1, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0);
        check_eq("rs_fetch_ready", 32'(if_req_ready), 32'd1);
        idle();
        check_eq("rs_fetch_valid", 32'(if_rsp_valid), 32'd1);
        check_eq("rs_fetch_inst", if_rsp_inst, M0);

        // Out-of-range addresses alias onto the BRAM
        cyc(0, 0, 32'h0, 0, 1, 0, 4'h0, 32'h4000, 32'h0, 0, 0, 0);
        check_eq("alias_d_addr", 32'(bram_addr), 32'd0);
        cyc(0, 1, 32'h4008, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0);
        check_eq("alias_if_addr", 32'(bram_addr), 32'd2);
        check_eq("alias_d_rdata", d_rsp_rdata, M0);
        idle();
        check_eq("alias_if_inst", if_rsp_inst, M2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
